// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-skip adder.
// Defaults describe the 16-bit, 4-bit-block, 2-rank configuration.
package csa_pkg;

    localparam int WIDTH_D    = 16;
    localparam int BLOCK_D    = 4;
    localparam int STAGES_D   = 2;
    localparam int NBLK       = WIDTH_D / BLOCK_D;
    localparam int BPS        = NBLK / STAGES_D;
    localparam int SKIP_CNT_W = 16;

    function automatic bit cfg_ok(input int w, input int b, input int s);
        return (b > 0) && (s >= 1) && (w % b == 0) && ((w / b) % s == 0);
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One BLOCK-bit ripple adder slice with full-propagate detect.
// The bypass mux lets the block carry-in skip straight to carry-out.
module csa_skip_block
    import csa_pkg::*;
#(
    parameter int BLOCK = BLOCK_D
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co,
    output logic             p
);

    logic w_rc;

    // Ripple the block, then pick bypass or ripple carry-out
    always_comb begin
        s    = '0;
        w_rc = ci;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = a[i] ^ b[i] ^ w_rc;
            w_rc = (a[i] & b[i]) | (w_rc & (a[i] ^ b[i]));
        end
        p  = &(a ^ b);
        co = p ? ci : w_rc;
    end

endmodule

// File: rtl/csa_skip_pipe.sv
// Pipelined carry-skip adder: STAGES ranks, valid/ready per rank.
// Optional macro CSA_SKIP_STATS_EN adds the skip_cnt bypass counter.
module csa_skip_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH  = WIDTH_D,
    parameter int BLOCK  = BLOCK_D,
    parameter int STAGES = STAGES_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CSA_SKIP_STATS_EN
    ,
    output logic [SKIP_CNT_W-1:0] skip_cnt
`endif
);

    localparam int NB = WIDTH / BLOCK;
    localparam int BP = NB / STAGES;
    localparam int L  = STAGES - 1;

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
        $error("csa_skip_pipe: WIDTH/BLOCK/STAGES not divisible");
    end

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;

    logic [WIDTH-1:0] w_sa [STAGES];
    logic [WIDTH-1:0] w_sb [STAGES];
    logic [WIDTH-1:0] w_ss [STAGES];
    logic [WIDTH-1:0] w_ns [STAGES];
    logic [STAGES-1:0] w_sc;
    logic [STAGES-1:0] w_nc;
    logic [STAGES-1:0] w_up;
    logic [STAGES-1:0] w_ld;

    logic [NB-1:0][BLOCK-1:0] w_bs;
    logic [NB-1:0]            w_bp;
    logic                     w_unused_p;

    // Each stage works on the previous rank's bundle; stage 0 on the ports
    always_comb begin
        w_sa[0] = a;
        w_sb[0] = b;
        w_ss[0] = '0;
        w_sc[0] = cin;
        w_up[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_sa[k] = r_a[k-1];
            w_sb[k] = r_b[k-1];
            w_ss[k] = r_s[k-1];
            w_sc[k] = r_c[k-1];
            w_up[k] = r_v[k-1];
        end
    end

    // A rank captures when empty or when its content moves on this cycle
    always_comb begin
        w_ld    = '0;
        w_ld[L] = !r_v[L] | out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            w_ld[k] = !r_v[k] | w_ld[k+1];
        end
    end

    assign in_ready = !rst & w_ld[0];

    for (genvar j = 0; j < NB; j++) begin : g_blk
        localparam int K = j / BP;
        logic             ci;
        logic             co;
        logic             p;
        logic [BLOCK-1:0] s;

        if (j % BP == 0) begin : g_first
            assign ci = w_sc[K];
        end else begin : g_next
            assign ci = g_blk[j-1].co;
        end

        csa_skip_block #(.BLOCK(BLOCK)) u_blk (
            .a  (w_sa[K][j*BLOCK +: BLOCK]),
            .b  (w_sb[K][j*BLOCK +: BLOCK]),
            .ci (ci),
            .s  (s),
            .co (co),
            .p  (p)
        );

        assign w_bs[j] = s;
        assign w_bp[j] = p;
    end

    assign w_unused_p = ^w_bp;

    for (genvar k = 0; k < STAGES; k++) begin : g_cout
        assign w_nc[k] = g_blk[(k+1)*BP-1].co;
    end

    // Splice each stage's resolved blocks into the travelling partial sum
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_ns[k] = w_ss[k];
            for (int j = 0; j < BP; j++) begin
                w_ns[k][(k*BP+j)*BLOCK +: BLOCK] = w_bs[k*BP+j];
            end
        end
    end

    // Rank registers; data only clocks when a valid bundle arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= w_up[k];
                    if (w_up[k]) begin
                        r_a[k] <= w_sa[k];
                        r_b[k] <= w_sb[k];
                        r_s[k] <= w_ns[k];
                        r_c[k] <= w_nc[k];
                    end
                end
            end
        end
    end

    assign out_valid = r_v[L];
    assign sum       = r_s[L];
    assign cout      = r_c[L];
    assign ovf       = (r_a[L][WIDTH-1] == r_b[L][WIDTH-1]) &
                       (r_s[L][WIDTH-1] != r_a[L][WIDTH-1]);

`ifdef CSA_SKIP_STATS_EN
    logic [NB-1:0]           w_pin;
    logic [SKIP_CNT_W:0]     w_cnt_sum;
    logic [SKIP_CNT_W-1:0]   r_cnt;

    // Full-propagate blocks of the incoming operands, added to the count
    always_comb begin
        w_pin = '0;
        for (int j = 0; j < NB; j++) begin
            w_pin[j] = &(a[j*BLOCK +: BLOCK] ^ b[j*BLOCK +: BLOCK]);
        end
        w_cnt_sum = {1'b0, r_cnt} +
                    (SKIP_CNT_W+1)'(popcount(64'(w_pin)));
    end

    // Saturating bypass counter, bumped on every accepted operand pair
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (in_valid & in_ready) begin
            r_cnt <= w_cnt_sum[SKIP_CNT_W] ? '1 : w_cnt_sum[SKIP_CNT_W-1:0];
        end
    end

    assign skip_cnt = r_cnt;
`endif

endmodule
